// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, derived totals, state and pattern encodings for the
// LCD timing generator and its lock qualifier.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRID     = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_WHITE    = 2'd3
    } pat_sel_e;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } lcd_state_e;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out
    // of the index bits: red off for bit1, green off for bit2, blue off for bit0.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        return {{5{~idx[1]}}, {6{~idx[2]}}, {5{~idx[0]}}};
    endfunction

endpackage

// File: rtl/lcd_timing_gen_lock_sync.sv
// Brings the asynchronous PLL lock flag into the pixel clock domain and
// qualifies it with a run of consecutive locked cycles.
module lock_sync #(
    parameter int LOCK_WAIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_synced,
    output logic lock_stable
);

    localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    logic          sync_meta;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= 1'b0;
            lock_synced <= 1'b0;
        end else begin
            sync_meta   <= pll_lock;
            lock_synced <= sync_meta;
        end
    end

    // Any unlocked cycle restarts the count; it saturates once qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
        end else if (!lock_synced) begin
            stable_cnt <= '0;
        end else if (stable_cnt != CW'(LOCK_WAIT - 1)) begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

    assign lock_stable = lock_synced && (stable_cnt == CW'(LOCK_WAIT - 1));

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: waits for a stable PLL lock, then scans frames and
// emits registered sync/enable strobes with a selectable RGB565 test pattern.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int LOCK_WAIT = 1024,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic [1:0] pat_sel,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [4:0] r,
    output logic [5:0] g,
    output logic [4:0] b,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    lcd_state_e  state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    pat_sel_e    pat_q;
    logic        lock_synced;
    logic        lock_stable;

    logic        frame_start;
    pat_sel_e    cur_pat;
    logic [9:0]  xv;
    logic [8:0]  yv;
    logic        in_active;
    logic        hs_win;
    logic        vs_win;
    int          bar_n;
    logic [15:0] pix;

    lock_sync #(.LOCK_WAIT(LOCK_WAIT)) u_lock_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .lock_synced(lock_synced),
        .lock_stable(lock_stable)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            running <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_synced) state <= STABILIZE;
                end
                STABILIZE: begin
                    if (!lock_synced) begin
                        state <= WAIT_LOCK;
                    end else if (lock_stable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_synced) begin
                        state   <= WAIT_LOCK;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // The pattern for the first pixel of a frame comes straight from pat_sel,
    // so the frame that samples it already shows it.
    always_comb begin
        frame_start = (hcnt == '0) && (vcnt == '0);
        cur_pat     = frame_start ? pat_sel_e'(pat_sel) : pat_q;
        xv          = 10'(hcnt);
        yv          = 9'(vcnt);
        in_active   = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
        hs_win      = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
        vs_win      = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
        bar_n       = int'(hcnt) / BAR_W;
        if (bar_n > 7) bar_n = 7;
        case (cur_pat)
            PAT_BARS:     pix = bar_colour(3'(bar_n));
            PAT_GRID:     pix = ((xv[4:0] == 5'd0) || (yv[4:0] == 5'd0) ||
                                 (int'(hcnt) == H_ACTIVE - 1) || (int'(vcnt) == V_ACTIVE - 1))
                                ? 16'hFFFF : 16'h0000;
            PAT_GRADIENT: pix = {xv[9:5], yv[8:3], ~xv[9:5]};
            default:      pix = 16'hFFFF;
        endcase
        if (!in_active) pix = 16'h0000;
    end

    // Scanning stops on the same edge the synced lock is seen low, so the
    // strobes, counters and running all drop together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            pat_q     <= PAT_BARS;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            de        <= 1'b0;
            {r, g, b} <= 16'h0000;
        end else if (state == RUN && lock_synced) begin
            hsync     <= hs_win ? SYNC_POL : ~SYNC_POL;
            vsync     <= vs_win ? SYNC_POL : ~SYNC_POL;
            de        <= in_active;
            {r, g, b} <= pix;
            if (frame_start) pat_q <= pat_sel_e'(pat_sel);
            if (hcnt == HW'(H_TOTAL - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end else begin
            hcnt      <= '0;
            vcnt      <= '0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            de        <= 1'b0;
            {r, g, b} <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a reference model queues the expected strobes and
// pixel for every cycle, a negedge monitor pops and compares against the DUT.
module tb_lcd_timing_gen;

    localparam int H_ACTIVE  = 96;
    localparam int H_FP      = 4;
    localparam int H_SYNC    = 8;
    localparam int H_BP      = 4;
    localparam int V_ACTIVE  = 40;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 3;
    localparam int V_BP      = 3;
    localparam int LOCK_WAIT = 64;
    localparam bit SYNC_POL  = 1'b0;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME     = H_TOTAL * V_TOTAL;
    localparam logic [19:0] INACTIVE = {1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 16'h0000};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic [1:0] pat_sel;
    logic       hsync, vsync, de, running;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;

    int checks = 0;
    int errors = 0;
    int de_model = 0;
    int de_dut = 0;

    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .LOCK_WAIT(LOCK_WAIT), .SYNC_POL(SYNC_POL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pll_lock(pll_lock),
        .pat_sel (pat_sel),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .r       (r),
        .g       (g),
        .b       (b),
        .running (running)
    );

    function automatic logic [15:0] bar_rgb(input int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_pixel(input int x, input int y, input logic [1:0] pat);
        logic [15:0] xb;
        logic [15:0] yb;
        xb = 16'(x);
        yb = 16'(y);
        case (pat)
            2'd0: return bar_rgb(x / (H_ACTIVE / 8));
            2'd1: return ((x % 32 == 0) || (y % 32 == 0) || (x == H_ACTIVE - 1) || (y == V_ACTIVE - 1))
                         ? 16'hFFFF : 16'h0000;
            2'd2: return {xb[9:5], yb[8:3], ~xb[9:5]};
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h (run,hs,vs,de,rgb)", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic [1:0] pat, input int cycles);
        @(negedge clk);
        pll_lock = lock;
        pat_sel  = pat;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: the synced lock is pll_lock two edges late; the scan
    // runs once LOCK_WAIT consecutive synced-high samples have been seen, and
    // each scanning cycle emits the next raster position of the frame.
    logic        m_l1, m_l2;
    int          m_run;
    bit          m_running;
    int          m_pos;
    logic [1:0]  m_pat;

    always @(posedge clk or negedge rst_n) begin
        logic        s;
        bit          prev;
        int          x, y;
        logic        e_de, e_hs, e_vs;
        logic [15:0] e_rgb;
        if (!rst_n) begin
            m_l1 = 1'b0;
            m_l2 = 1'b0;
            m_run = 0;
            m_running = 1'b0;
            m_pos = 0;
            m_pat = 2'd0;
            exp_q.delete();
        end else begin
            s = m_l2;
            m_l2 = m_l1;
            m_l1 = pll_lock;
            prev = m_running;
            m_run = s ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
            m_running = (m_run >= LOCK_WAIT);
            e_de = 1'b0;
            e_hs = ~SYNC_POL;
            e_vs = ~SYNC_POL;
            e_rgb = 16'h0000;
            if (prev && m_running) begin
                x = m_pos % H_TOTAL;
                y = m_pos / H_TOTAL;
                if (m_pos == 0) m_pat = pat_sel;
                e_de = (x < H_ACTIVE) && (y < V_ACTIVE);
                if (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) e_hs = SYNC_POL;
                if (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) e_vs = SYNC_POL;
                if (e_de) begin
                    e_rgb = ref_pixel(x, y, m_pat);
                    de_model++;
                end
                m_pos = (m_pos + 1) % FRAME;
            end else begin
                m_pos = 0;
            end
            exp_q.push_back({m_running, e_hs, e_vs, e_de, e_rgb});
        end
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (de === 1'b1) de_dut++;
            checkOutput("cycle", {running, hsync, vsync, de, r, g, b}, e);
        end
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        pat_sel  = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {running, hsync, vsync, de, r, g, b}, INACTIVE);

        rst_n = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 4 * LOCK_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("running_rise", 20'(n), 20'(LOCK_WAIT + 2));

        $display("[TB] colour bars, then mid-frame switch to solid white");
        applyStimulus(1'b1, 2'd0, FRAME + FRAME / 2);
        applyStimulus(1'b1, 2'd3, FRAME);
        applyStimulus(1'b1, 2'd1, FRAME);
        applyStimulus(1'b1, 2'd2, FRAME);

        $display("[TB] single-cycle lock glitch while stabilizing");
        applyStimulus(1'b0, 2'd0, 4);
        applyStimulus(1'b1, 2'd0, LOCK_WAIT / 2);
        applyStimulus(1'b0, 2'd0, 1);
        applyStimulus(1'b1, 2'd0, LOCK_WAIT + 8);

        $display("[TB] lock lost mid-frame and relock");
        applyStimulus(1'b1, 2'd1, 20 * H_TOTAL + 17);
        applyStimulus(1'b0, 2'd1, 5);
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), LOCK_WAIT + FRAME);

        $display("[TB] random lock activity");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(1, 150));
        end
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), LOCK_WAIT + 3 * H_TOTAL);

        $display("[TB] asynchronous reset while scanning");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {running, hsync, vsync, de, r, g, b}, INACTIVE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), LOCK_WAIT + 4 * H_TOTAL);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 20'(exp_q.size()), 20'(0));
        checkOutput("de_total", 20'(de_dut), 20'(de_model));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
